// File: rtl/dff_share_arbiter_pkg.sv
// ============================================================================
// dff_share_arbiter_pkg : shared types and constants for the register arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package dff_share_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Saturating increment used for the per-grant write counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] limit);
        return (val >= limit) ? limit : val + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dff_share_arbiter_rr_select.sv
// ============================================================================
// rr_select : combinational rotate-priority picker starting after last_owner
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_select #(
    parameter  int NREQ = 4,
    localparam int OWNW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OWNW-1:0] last_owner,
    output logic [OWNW-1:0] sel,
    output logic            any
);

    logic [OWNW-1:0] w_idx;

    // Scan farthest-first so the nearest set bit after last_owner overwrites.
    // NREQ is a power of two, so the OWNW-bit add wraps modulo NREQ.
    always_comb begin
        sel   = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = last_owner + OWNW'(k);
            if (req[w_idx]) begin
                sel = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dff_share_arbiter.sv
// ============================================================================
// dff_share_arbiter : round-robin owner of a single shared WIDTH-bit register
// Revision 1.0
// ============================================================================
`default_nettype none

module dff_share_arbiter
    import dff_share_arbiter_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int NREQ     = 4,
    parameter  int MAX_HOLD = 4,
    localparam int OWNW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [OWNW-1:0]       owner,
    output logic                  busy
);

    state_t            state_q;
    logic [OWNW-1:0]   owner_q;
    logic [OWNW-1:0]   last_q;
    logic [7:0]        hold_q;
    logic [7:0]        hold_d;
    logic [NREQ-1:0]   gnt_q;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  data_d;

    logic [OWNW-1:0]   w_sel;
    logic              w_any;
    logic              w_own_req;
    logic              w_others;
    logic              w_hold_full;

    rr_select #(.NREQ(NREQ)) u_rr_select (
        .req        (req),
        .last_owner (last_q),
        .sel        (w_sel),
        .any        (w_any)
    );

    assign w_own_req   = req[owner_q];
    assign w_others    = |(req & ~gnt_q);
    assign w_hold_full = (hold_q == 8'(MAX_HOLD));
    assign hold_d      = sat_inc(hold_q, 8'(MAX_HOLD));
    assign data_d      = wdata[owner_q*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= OWNW'(NREQ-1);
            hold_q  <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_any) begin
                        state_q <= ST_OWN;
                        owner_q <= w_sel;
                        last_q  <= w_sel;
                        hold_q  <= '0;
                        gnt_q   <= NREQ'(1) << w_sel;
                    end
                end
                ST_OWN: begin
                    // Release costs one idle bubble; no write on the release edge.
                    if (!w_own_req || (w_hold_full && w_others)) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                    end else begin
                        data_q  <= data_d;
                        hold_q  <= hold_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign q     = data_q;
    assign owner = owner_q;
    assign busy  = |gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dff_share_arbiter.sv
// ============================================================================
// tb_dff_share_arbiter : directed self-checking bench for dff_share_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dff_share_arbiter;

    localparam int WIDTH    = 8;
    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;

    logic                  clk = 1'b0;
    logic                  clr;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [1:0]            owner;
    logic                  busy;

    int n_chk = 0;
    int n_err = 0;

    dff_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .clr   (clr),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int i, input logic [7:0] v);
        wdata[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        clr   = 1'b1;
        req   = 4'b1111;
        wdata = '0;
        set_slice(0, 8'h11);
        set_slice(1, 8'h22);
        set_slice(2, 8'hA5);
        set_slice(3, 8'h44);

        // Reset held two cycles with all requests asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_q", 32'(q), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
        end
        clr = 1'b0;
        tick();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        tick();
        check("drop_idle", 32'(gnt), 32'h0);
        check("drop_q", 32'(q), 32'h0);

        // Single requester 2: grant, then write one edge later
        req = 4'b0100;
        tick();
        check("r2_gnt", 32'(gnt), 32'h4);
        check("r2_owner", 32'(owner), 32'h2);
        check("r2_q_before", 32'(q), 32'h0);
        tick();
        check("r2_q", 32'(q), 32'hA5);
        set_slice(2, 8'h3C);
        tick();
        check("r2_q2", 32'(q), 32'h3C);

        // Clear mid-ownership, then restart from requester 0
        clr = 1'b1;
        tick();
        check("clr_q", 32'(q), 32'h0);
        check("clr_gnt", 32'(gnt), 32'h0);
        check("clr_owner", 32'(owner), 32'h0);
        clr = 1'b0;
        req = 4'b1111;
        tick();
        check("clr_regrant", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("clr_release", 32'(gnt), 32'h0);

        // Two contenders: last owner was 0, so 1 goes first
        req = 4'b0011;
        tick();
        check("rr_gnt_a", 32'(gnt), 32'h2);
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < MAX_HOLD; w++) begin
                tick();
                check("rr_hold_gnt", 32'(gnt), (r == 0) ? 32'h2 : 32'h1);
                check("rr_hold_q", 32'(q), (r == 0) ? 32'h22 : 32'h11);
            end
            tick();
            check("rr_bubble", 32'(gnt), 32'h0);
            check("rr_bubble_q", 32'(q), (r == 0) ? 32'h22 : 32'h11);
            tick();
            check("rr_next", 32'(gnt), (r == 0) ? 32'h1 : 32'h2);
        end

        // Owner 1 drops after two writes while 3 waits
        set_slice(1, 8'h55);
        req = 4'b1010;
        tick();
        tick();
        check("drop2_gnt", 32'(gnt), 32'h2);
        check("drop2_q", 32'(q), 32'h55);
        set_slice(1, 8'h66);
        req = 4'b1000;
        tick();
        check("drop2_rel", 32'(gnt), 32'h0);
        check("drop2_rel_q", 32'(q), 32'h55);
        tick();
        check("drop2_g3", 32'(gnt), 32'h8);
        check("drop2_own3", 32'(owner), 32'h3);
        tick();
        check("drop2_w3", 32'(q), 32'h44);
        req = 4'b0000;
        tick();
        check("drop2_idle", 32'(gnt), 32'h0);

        // Lone requester keeps writing past MAX_HOLD; late waiter forces release
        req = 4'b0010;
        tick();
        check("sat_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 10; i++) begin
            set_slice(1, 8'(8'h80 + i));
            tick();
            check("sat_hold_gnt", 32'(gnt), 32'h2);
            check("sat_hold_q", 32'(q), 32'(8'h80 + i));
        end
        set_slice(1, 8'hEE);
        req = 4'b1010;
        tick();
        check("sat_rel", 32'(gnt), 32'h0);
        check("sat_rel_q", 32'(q), 32'h89);
        check("sat_rel_busy", 32'(busy), 32'h0);
        tick();
        check("sat_g3", 32'(gnt), 32'h8);
        check("sat_busy", 32'(busy), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
